// File: rtl/mjpg_stream_parser.sv
// JPEG marker-structure walker for a byte stream: captures SOF0 dimensions, strips
// 0xFF00 stuffing from the entropy-coded segment and flags malformed streams.
module mjpg_stream_parser #(
  parameter int unsigned CNTW         = 24,
  parameter bit          SOF_REQUIRED = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            jvalid,
  input  logic [7:0]      jpeg,
  output logic            ecs_valid,
  output logic [7:0]      ecs_data,
  output logic            sof,
  output logic            eof,
  output logic            rstm,
  output logic [2:0]      rstm_idx,
  output logic [15:0]     width,
  output logic [15:0]     height,
  output logic            dim_valid,
  output logic [CNTW-1:0] ecs_count,
  output logic            err,
  output logic [2:0]      err_code
);

  typedef enum logic [2:0] {
    StHunt, StHuntFf, StMrk, StLenH, StLenL, StBody, StEcs, StEcsFf
  } state_e;

  localparam logic [7:0] MkSoi = 8'hD8;
  localparam logic [7:0] MkEoi = 8'hD9;
  localparam logic [7:0] MkSof = 8'hC0;
  localparam logic [7:0] MkSos = 8'hDA;

  localparam logic [2:0] ENoSoi  = 3'd1;
  localparam logic [2:0] EBadLen = 3'd2;
  localparam logic [2:0] EBadEsc = 3'd3;
  localparam logic [2:0] ENoSof  = 3'd4;
  localparam logic [2:0] EReSoi  = 3'd5;

  state_e          state_q, state_d;
  logic            mrk_ff_q, mrk_ff_d;
  logic [7:0]      marker_q, marker_d;
  logic [7:0]      len_h_q, len_h_d;
  logic [15:0]     rem_q, rem_d;
  logic [2:0]      idx_q, idx_d;
  logic [15:0]     x_q, x_d, y_q, y_d;
  logic            ecs_valid_q, ecs_valid_d;
  logic [7:0]      ecs_data_q, ecs_data_d;
  logic            sof_q, sof_d, eof_q, eof_d, rstm_q, rstm_d, err_q, err_d;
  logic [2:0]      rstm_idx_q, rstm_idx_d, err_code_q, err_code_d;
  logic [15:0]     width_q, width_d, height_q, height_d;
  logic            dim_valid_q, dim_valid_d;
  logic [CNTW-1:0] ecs_count_q, ecs_count_d;

  logic        is_ff, is_rst, seg_end, do_err, do_sof, do_emit;
  logic [2:0]  code;
  logic [7:0]  emit_byte;
  logic [15:0] len;

  always_comb begin
    state_d     = state_q;
    mrk_ff_d    = mrk_ff_q;
    marker_d    = marker_q;
    len_h_d     = len_h_q;
    rem_d       = rem_q;
    idx_d       = idx_q;
    x_d         = x_q;
    y_d         = y_q;
    ecs_valid_d = 1'b0;
    ecs_data_d  = ecs_data_q;
    sof_d       = 1'b0;
    eof_d       = 1'b0;
    rstm_d      = 1'b0;
    rstm_idx_d  = rstm_idx_q;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    width_d     = width_q;
    height_d    = height_q;
    dim_valid_d = dim_valid_q;
    ecs_count_d = ecs_count_q;
    seg_end     = 1'b0;
    do_err      = 1'b0;
    do_sof      = 1'b0;
    do_emit     = 1'b0;
    code        = 3'd0;
    emit_byte   = jpeg;
    is_ff       = (jpeg == 8'hFF);
    is_rst      = (jpeg[7:3] == 5'b11010);
    len         = {len_h_q, jpeg};

    if (jvalid) begin
      unique case (state_q)
        StHunt: if (is_ff) state_d = StHuntFf;
        StHuntFf: begin
          if (jpeg == MkSoi) do_sof = 1'b1;
          else if (!is_ff)   state_d = StHunt;
        end
        StMrk: begin
          if (!mrk_ff_q) begin
            if (is_ff) mrk_ff_d = 1'b1;
            else begin
              do_err = 1'b1;
              code   = ENoSoi;
            end
          end else if (is_ff) begin
            mrk_ff_d = 1'b1;
          end else if (jpeg == MkSoi) begin
            do_sof = 1'b1;
          end else if (jpeg == MkEoi) begin
            eof_d   = 1'b1;
            state_d = StHunt;
          end else if (jpeg == 8'h00 || is_rst) begin
            do_err = 1'b1;
            code   = ENoSoi;
          end else begin
            marker_d = jpeg;
            mrk_ff_d = 1'b0;
            state_d  = StLenH;
          end
        end
        StLenH: begin
          len_h_d = jpeg;
          state_d = StLenL;
        end
        StLenL: begin
          if (len < 16'd2 || (marker_q == MkSof && len < 16'd7)) begin
            do_err = 1'b1;
            code   = EBadLen;
          end else if (len == 16'd2) begin
            seg_end = 1'b1;
          end else begin
            rem_d   = len - 16'd2;
            idx_d   = 3'd0;
            state_d = StBody;
          end
        end
        StBody: begin
          rem_d = rem_q - 16'd1;
          if (idx_q != 3'd7) idx_d = idx_q + 3'd1;
          // SOF0 body: precision, Y (2 bytes), X (2 bytes), components
          if (marker_q == MkSof) begin
            case (idx_q)
              3'd1:    y_d[15:8] = jpeg;
              3'd2:    y_d[7:0]  = jpeg;
              3'd3:    x_d[15:8] = jpeg;
              3'd4:    x_d[7:0]  = jpeg;
              default: ;
            endcase
          end
          if (rem_q == 16'd1) begin
            seg_end = 1'b1;
            if (marker_q == MkSof) begin
              width_d     = x_d;
              height_d    = y_d;
              dim_valid_d = 1'b1;
            end
          end
        end
        StEcs: begin
          if (is_ff) state_d = StEcsFf;
          else       do_emit = 1'b1;
        end
        StEcsFf: begin
          if (jpeg == 8'h00) begin
            do_emit   = 1'b1;
            emit_byte = 8'hFF;
            state_d   = StEcs;
          end else if (is_ff) begin
            state_d = StEcsFf;
          end else if (is_rst) begin
            rstm_d     = 1'b1;
            rstm_idx_d = jpeg[2:0];
            state_d    = StEcs;
          end else if (jpeg == MkEoi) begin
            eof_d   = 1'b1;
            state_d = StHunt;
          end else if (jpeg == MkSoi) begin
            do_err = 1'b1;
            code   = EReSoi;
            do_sof = 1'b1;
          end else begin
            do_err = 1'b1;
            code   = EBadEsc;
          end
        end
        default: state_d = StHunt;
      endcase
    end

    if (seg_end) begin
      if (marker_q == MkSos) begin
        if (SOF_REQUIRED && !dim_valid_q) begin
          do_err = 1'b1;
          code   = ENoSof;
        end else begin
          state_d = StEcs;
        end
      end else begin
        mrk_ff_d = 1'b0;
        state_d  = StMrk;
      end
    end

    if (do_emit) begin
      ecs_valid_d = 1'b1;
      ecs_data_d  = emit_byte;
      if (ecs_count_q != '1) ecs_count_d = ecs_count_q + CNTW'(1);
    end

    if (do_err) begin
      err_d       = 1'b1;
      err_code_d  = code;
      dim_valid_d = 1'b0;
      state_d     = StHunt;
    end

    // A new SOI wins over the error's return to HUNT (restart inside ECS)
    if (do_sof) begin
      sof_d       = 1'b1;
      ecs_count_d = '0;
      dim_valid_d = 1'b0;
      mrk_ff_d    = 1'b0;
      state_d     = StMrk;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StHunt;
      mrk_ff_q    <= 1'b0;
      marker_q    <= 8'h00;
      len_h_q     <= 8'h00;
      rem_q       <= 16'h0000;
      idx_q       <= 3'd0;
      x_q         <= 16'h0000;
      y_q         <= 16'h0000;
      ecs_valid_q <= 1'b0;
      ecs_data_q  <= 8'h00;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      rstm_q      <= 1'b0;
      rstm_idx_q  <= 3'd0;
      err_q       <= 1'b0;
      err_code_q  <= 3'd0;
      width_q     <= 16'h0000;
      height_q    <= 16'h0000;
      dim_valid_q <= 1'b0;
      ecs_count_q <= '0;
    end else begin
      state_q     <= state_d;
      mrk_ff_q    <= mrk_ff_d;
      marker_q    <= marker_d;
      len_h_q     <= len_h_d;
      rem_q       <= rem_d;
      idx_q       <= idx_d;
      x_q         <= x_d;
      y_q         <= y_d;
      ecs_valid_q <= ecs_valid_d;
      ecs_data_q  <= ecs_data_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
      rstm_q      <= rstm_d;
      rstm_idx_q  <= rstm_idx_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      width_q     <= width_d;
      height_q    <= height_d;
      dim_valid_q <= dim_valid_d;
      ecs_count_q <= ecs_count_d;
    end
  end

  assign ecs_valid = ecs_valid_q;
  assign ecs_data  = ecs_data_q;
  assign sof       = sof_q;
  assign eof       = eof_q;
  assign rstm      = rstm_q;
  assign rstm_idx  = rstm_idx_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign width     = width_q;
  assign height    = height_q;
  assign dim_valid = dim_valid_q;
  assign ecs_count = ecs_count_q;

endmodule
